// File: rtl/seq_signed_divider_if.sv
// Start/done handshake and operand/result bus for the sequential signed divider.
interface seq_signed_divider_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_signed_divider.sv
// Sequential two's-complement divider: restoring shift-subtract on magnitudes,
// one quotient bit per clock, then sign fixup. Truncates toward zero like SV / and %.
module seq_signed_divider #(
    parameter int unsigned WIDTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    seq_signed_divider_if.slave bus
);
    localparam int unsigned    CW      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] NEG_ONE = '1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] mag_b;
    logic [CW-1:0]    cnt;
    logic             sign_a;
    logic             neg_q;
    logic             dz_pend;
    logic             ov_pend;
    logic [WIDTH-1:0] dividend_q;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dz_r;
    logic             ov_r;

    logic [WIDTH-1:0] abs_a_c;
    logic [WIDTH-1:0] abs_b_c;
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH-1:0] diff_c;
    logic             ge_c;

    // Magnitudes are unsigned WIDTH so |MIN| fits; the compare runs at WIDTH+1 bits.
    always_comb begin
        abs_a_c   = bus.dividend[WIDTH-1] ? WIDTH'(~bus.dividend + 1'b1) : bus.dividend;
        abs_b_c   = bus.divisor[WIDTH-1]  ? WIDTH'(~bus.divisor + 1'b1)  : bus.divisor;
        shifted_c = {rem, work[WIDTH-1]};
        ge_c      = (shifted_c >= {1'b0, mag_b});
        diff_c    = shifted_c[WIDTH-1:0] - mag_b;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem         <= '0;
            work        <= '0;
            mag_b       <= '0;
            cnt         <= '0;
            sign_a      <= 1'b0;
            neg_q       <= 1'b0;
            dz_pend     <= 1'b0;
            ov_pend     <= 1'b0;
            dividend_q  <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dz_r        <= 1'b0;
            ov_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dividend_q <= bus.dividend;
                        sign_a     <= bus.dividend[WIDTH-1];
                        neg_q      <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        work       <= abs_a_c;
                        mag_b      <= abs_b_c;
                        rem        <= '0;
                        cnt        <= CW'(WIDTH - 1);
                        dz_pend    <= (bus.divisor == '0);
                        ov_pend    <= (bus.dividend == MIN_VAL) && (bus.divisor == NEG_ONE);
                        busy_r     <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    rem  <= ge_c ? diff_c : shifted_c[WIDTH-1:0];
                    work <= {work[WIDTH-2:0], ge_c};
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    // Zero divisor bypasses the datapath so the remainder keeps the dividend's sign.
                    if (dz_pend) begin
                        quotient_r  <= NEG_ONE;
                        remainder_r <= dividend_q;
                    end else begin
                        quotient_r  <= neg_q  ? WIDTH'(~work + 1'b1) : work;
                        remainder_r <= sign_a ? WIDTH'(~rem + 1'b1)  : rem;
                    end
                    dz_r   <= dz_pend;
                    ov_r   <= ov_pend;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dz_r;
    assign bus.overflow    = ov_r;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider at WIDTH=4 (directed + exhaustive) and WIDTH=8 (random).
module tb_seq_signed_divider;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_signed_divider_if #(.WIDTH(4)) bus4();
    seq_signed_divider_if #(.WIDTH(8)) bus8();

    seq_signed_divider #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    seq_signed_divider #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: plain signed integer division with the two defined special cases.
    function automatic exp_t model(input int w, input logic [7:0] ab, input logic [7:0] bb, input int c);
        exp_t e;
        int   a, b, qi, ri;
        logic [7:0] m;
        m = 8'((1 << w) - 1);
        a = int'(ab & m);
        b = int'(bb & m);
        if (a >= (1 << (w - 1))) a -= (1 << w);
        if (b >= (1 << (w - 1))) b -= (1 << w);
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (b == 0) begin
            qi = -1; ri = a; e.dz = 1'b1;
        end else if (a == -(1 << (w - 1)) && b == -1) begin
            qi = a; ri = 0; e.ov = 1'b1;
        end else begin
            qi = a / b; ri = a % b;
        end
        e.a   = ab & m;
        e.b   = bb & m;
        e.q   = 8'(qi) & m;
        e.r   = 8'(ri) & m;
        e.cyc = c;
        return e;
    endfunction

    // Issue one WIDTH=4 operation at the first idle cycle; expected result enters the scoreboard.
    task automatic issue4(input logic [3:0] a, input logic [3:0] b);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus4.busy) begin ok = 1; break; end
        end
        if (!ok) chk("w4 issue idle timeout", 1, 0);
        bus4.start    = 1'b1;
        bus4.dividend = a;
        bus4.divisor  = b;
        q4.push_back(model(4, 8'(a), 8'(b), cyc + 1 + 5));
        @(negedge clk);
        bus4.start    = 1'b0;
        bus4.dividend = 4'($urandom);
        bus4.divisor  = 4'($urandom);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus8.busy) begin ok = 1; break; end
        end
        if (!ok) chk("w8 issue idle timeout", 1, 0);
        bus8.start    = 1'b1;
        bus8.dividend = a;
        bus8.divisor  = b;
        q8.push_back(model(8, a, b, cyc + 1 + 9));
        @(negedge clk);
        bus8.start    = 1'b0;
        bus8.dividend = 8'($urandom);
        bus8.divisor  = 8'($urandom);
    endtask

    task automatic drain(input int which);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            if ((which == 4 && q4.size() == 0) || (which == 8 && q8.size() == 0)) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("drain timeout (missing done)", 0, 1);
    endtask

    // WIDTH=4 monitor: pops on every done, also checks latency, busy, pulse width, hold stability.
    initial begin
        logic [3:0] hq = '0, hr = '0;
        logic hdz = 1'b0, hov = 1'b0, prev_done = 1'b0, unstable = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                hq = '0; hr = '0; hdz = 0; hov = 0; prev_done = 0; unstable = 0;
                continue;
            end
            if (bus4.done) begin
                if (q4.size() == 0) begin
                    chk("w4 unexpected done", 1, 0);
                end else begin
                    e = q4.pop_front();
                    chk($sformatf("w4 %0d/%0d quotient", e.a, e.b), int'(bus4.quotient), int'(e.q));
                    chk($sformatf("w4 %0d/%0d remainder", e.a, e.b), int'(bus4.remainder), int'(e.r));
                    chk($sformatf("w4 %0d/%0d div_by_zero", e.a, e.b), int'(bus4.div_by_zero), int'(e.dz));
                    chk($sformatf("w4 %0d/%0d overflow", e.a, e.b), int'(bus4.overflow), int'(e.ov));
                    chk($sformatf("w4 %0d/%0d done cycle", e.a, e.b), cyc, e.cyc);
                end
                chk("w4 busy during done", int'(bus4.busy), 0);
                chk("w4 done pulse width", int'(prev_done), 0);
                chk("w4 outputs held between dones", int'(unstable), 0);
                hq = bus4.quotient; hr = bus4.remainder; hdz = bus4.div_by_zero; hov = bus4.overflow;
                unstable = 0;
            end else if (bus4.quotient != hq || bus4.remainder != hr ||
                         bus4.div_by_zero != hdz || bus4.overflow != hov) begin
                unstable = 1;
            end
            prev_done = bus4.done;
        end
    end

    // WIDTH=8 monitor.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (rst_n && bus8.done) begin
                if (q8.size() == 0) begin
                    chk("w8 unexpected done", 1, 0);
                end else begin
                    e = q8.pop_front();
                    chk($sformatf("w8 %0d/%0d quotient", e.a, e.b), int'(bus8.quotient), int'(e.q));
                    chk($sformatf("w8 %0d/%0d remainder", e.a, e.b), int'(bus8.remainder), int'(e.r));
                    chk($sformatf("w8 %0d/%0d flags", e.a, e.b),
                        int'({bus8.div_by_zero, bus8.overflow}), int'({e.dz, e.ov}));
                    chk($sformatf("w8 %0d/%0d done cycle", e.a, e.b), cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int bc;
        bus4.start = 1'b0; bus4.dividend = '0; bus4.divisor = '0;
        bus8.start = 1'b0; bus8.dividend = '0; bus8.divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset outputs", int'({bus4.busy, bus4.done, bus4.quotient, bus4.remainder,
                                   bus4.div_by_zero, bus4.overflow}), 0);
        rst_n = 1'b1;

        // 7/2 with busy-length check over the cycles following the accepting edge
        issue4(4'd7, 4'd2);
        bc = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus4.busy) bc++;
            @(negedge clk);
        end
        chk("busy cycles for 7/2", bc, 5);

        issue4(4'(-7), 4'd2);
        issue4(4'd7, 4'(-2));
        issue4(4'(-8), 4'd3);
        issue4(4'(-8), 4'(-1));
        issue4(4'd5, 4'd0);
        issue4(4'd6, 4'd3);
        drain(4);

        // start re-pulsed mid-calculation with different operands must be ignored
        issue4(4'd7, 4'd3);
        @(negedge clk);
        bus4.start = 1'b1; bus4.dividend = 4'd1; bus4.divisor = 4'd1;
        @(negedge clk);
        bus4.start = 1'b0;
        drain(4);

        // reset mid-calculation abandons the operation
        issue4(4'd7, 4'd2);
        @(negedge clk);
        rst_n = 1'b0;
        q4.delete();
        @(negedge clk);
        chk("mid-op reset outputs", int'({bus4.busy, bus4.done, bus4.quotient, bus4.remainder,
                                          bus4.div_by_zero, bus4.overflow}), 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue4(4'(-6), 4'd4);
        drain(4);

        // every operand pair, back to back
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                issue4(4'(a), 4'(b));
        drain(4);

        issue8(8'h80, 8'hFF);
        issue8(8'd100, 8'd0);
        for (int i = 0; i < 1500; i++)
            issue8(8'($urandom), 8'($urandom_range(255, 0)));
        drain(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
